cfo_loop_ctrl: RTL and testbench

Gear-shift and lock controller for the CFO PI loop filter in the MSK receiver.
- Monitors the phase-detector error stream and averages |error| over fixed windows.
- Sequences the loop through acquisition, tracking and fine-tracking gain sets, and reports lock.
- Clears the loop-filter integrator on (re)acquisition or acquisition timeout.
- Sits between the phase detector and the loop filter, and drives the filter's gain-select and integrator-control inputs.

---
 rtl/cfo_loop_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_cfo_loop_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cfo_loop_ctrl.sv
// Gear-shift and lock controller for the MSK CFO PI loop filter.
// Windows |phase error|, steps ACQ -> TRACK -> FINE gain sets, reports lock, clears/holds the integrator.
module cfo_loop_ctrl #(
    parameter int ERR_WIDTH   = 24,
    parameter int LOG2_WIN    = 4,
    parameter int LOCK_THR    = 524288,
    parameter int FINE_THR    = 131072,
    parameter int LOSS_THR    = 2097152,
    parameter int LOCK_CNT    = 4,
    parameter int LOSS_CNT    = 2,
    parameter int ACQ_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic                 force_reacq_i,
    input  logic                 err_valid_i,
    input  logic [ERR_WIDTH-1:0] phase_err_i,
    output logic [1:0]           gain_sel_o,
    output logic                 integ_clr_o,
    output logic                 integ_hold_o,
    output logic                 lock_o,
    output logic [2:0]           state_o,
    output logic                 win_valid_o,
    output logic [ERR_WIDTH-2:0] win_mean_o
);
    localparam int MAG_W = ERR_WIDTH - 1;
    localparam int ACC_W = MAG_W + LOG2_WIN;
    localparam int LC_W  = $clog2(LOCK_CNT + 1);
    localparam int SC_W  = $clog2(LOSS_CNT + 1);
    localparam int AW_W  = $clog2(ACQ_TIMEOUT + 1);

    localparam logic [MAG_W-1:0] LOCK_THR_V = MAG_W'(LOCK_THR);
    localparam logic [MAG_W-1:0] FINE_THR_V = MAG_W'(FINE_THR);
    localparam logic [MAG_W-1:0] LOSS_THR_V = MAG_W'(LOSS_THR);
    localparam logic [LC_W-1:0]  LOCK_CNT_V = LC_W'(LOCK_CNT);
    localparam logic [SC_W-1:0]  LOSS_CNT_V = SC_W'(LOSS_CNT);
    localparam logic [AW_W-1:0]  ACQ_TO_V   = AW_W'(ACQ_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACQ   = 3'd2,
        S_TRACK = 3'd3,
        S_FINE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [LOG2_WIN-1:0] r_cnt;
    logic [LC_W-1:0]     r_lock_cnt;
    logic [SC_W-1:0]     r_loss_cnt;
    logic [AW_W-1:0]     r_acq_win;
    logic [MAG_W-1:0]    r_win_mean;
    logic                r_win_valid;
    logic [1:0]          r_gain_sel;
    logic                r_integ_clr;
    logic                r_integ_hold;
    logic                r_lock;

    state_t              w_state_next;
    logic [ACC_W-1:0]    w_acc_next;
    logic [LOG2_WIN-1:0] w_cnt_next;
    logic [LC_W-1:0]     w_lock_next;
    logic [SC_W-1:0]     w_loss_next;
    logic [AW_W-1:0]     w_acq_next;
    logic [MAG_W-1:0]    w_win_mean_next;
    logic                w_win_valid_next;

    // Saturating magnitude: the most negative code has no positive twin.
    logic             w_err_is_min;
    logic [MAG_W-1:0] w_neg_mag;
    logic [MAG_W-1:0] w_mag;
    logic [ACC_W-1:0] w_sum;
    logic [MAG_W-1:0] w_mean;
    logic             w_win_done;
    logic             w_loss_hit;

    assign w_err_is_min = (phase_err_i == {1'b1, {MAG_W{1'b0}}});
    assign w_neg_mag    = ~phase_err_i[MAG_W-1:0] + MAG_W'(1);
    assign w_mag        = !phase_err_i[ERR_WIDTH-1] ? phase_err_i[MAG_W-1:0] :
                          (w_err_is_min ? {MAG_W{1'b1}} : w_neg_mag);
    assign w_sum        = r_acc + ACC_W'(w_mag);
    assign w_mean       = w_sum[ACC_W-1:LOG2_WIN];
    assign w_win_done   = err_valid_i && (r_cnt == {LOG2_WIN{1'b1}});
    assign w_loss_hit   = (w_mean > LOSS_THR_V);

    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_cnt_next       = r_cnt;
        w_lock_next      = r_lock_cnt;
        w_loss_next      = r_loss_cnt;
        w_acq_next       = r_acq_win;
        w_win_mean_next  = r_win_mean;
        w_win_valid_next = 1'b0;

        if (!enable_i) begin
            w_state_next = S_IDLE;
        end else if (force_reacq_i && r_state != S_IDLE) begin
            w_state_next = S_CLEAR;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = S_CLEAR;
                S_CLEAR: w_state_next = S_ACQ;
                S_ACQ, S_TRACK, S_FINE: begin
                    if (err_valid_i && !w_win_done) begin
                        w_acc_next = w_sum;
                        w_cnt_next = r_cnt + LOG2_WIN'(1);
                    end else if (w_win_done) begin
                        w_acc_next       = '0;
                        w_cnt_next       = '0;
                        w_win_mean_next  = w_mean;
                        w_win_valid_next = 1'b1;
                        if (r_state == S_ACQ) begin
                            w_lock_next = (w_mean < LOCK_THR_V) ? r_lock_cnt + LC_W'(1) : '0;
                            w_acq_next  = r_acq_win + AW_W'(1);
                            // Lock beats timeout when both land on the same window.
                            if (w_lock_next == LOCK_CNT_V)
                                w_state_next = S_TRACK;
                            else if (w_acq_next == ACQ_TO_V)
                                w_state_next = S_CLEAR;
                        end else begin
                            w_loss_next = w_loss_hit ? r_loss_cnt + SC_W'(1) : '0;
                            if (r_state == S_TRACK)
                                w_lock_next = (w_mean < FINE_THR_V) ? r_lock_cnt + LC_W'(1) : '0;
                            if (w_loss_next == LOSS_CNT_V)
                                w_state_next = S_ACQ;
                            else if (r_state == S_TRACK && w_lock_next == LOCK_CNT_V)
                                w_state_next = S_FINE;
                            else if (r_state == S_FINE && w_mean >= LOCK_THR_V)
                                w_state_next = S_TRACK;
                        end
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end

        if (w_state_next != r_state) begin
            w_acc_next  = '0;
            w_cnt_next  = '0;
            w_lock_next = '0;
            w_acq_next  = '0;
            // The loss run survives gear changes within lock only.
            if (!((r_state == S_TRACK && w_state_next == S_FINE) ||
                  (r_state == S_FINE  && w_state_next == S_TRACK)))
                w_loss_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_lock_cnt   <= '0;
            r_loss_cnt   <= '0;
            r_acq_win    <= '0;
            r_win_mean   <= '0;
            r_win_valid  <= 1'b0;
            r_gain_sel   <= 2'd0;
            r_integ_clr  <= 1'b0;
            r_integ_hold <= 1'b1;
            r_lock       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_acc        <= w_acc_next;
            r_cnt        <= w_cnt_next;
            r_lock_cnt   <= w_lock_next;
            r_loss_cnt   <= w_loss_next;
            r_acq_win    <= w_acq_next;
            r_win_mean   <= w_win_mean_next;
            r_win_valid  <= w_win_valid_next;
            r_gain_sel   <= (w_state_next == S_TRACK) ? 2'd1 :
                            (w_state_next == S_FINE)  ? 2'd2 : 2'd0;
            r_integ_clr  <= (w_state_next == S_CLEAR);
            r_integ_hold <= (w_state_next == S_IDLE);
            r_lock       <= (w_state_next == S_TRACK) || (w_state_next == S_FINE);
        end
    end

    assign state_o      = r_state;
    assign gain_sel_o   = r_gain_sel;
    assign integ_clr_o  = r_integ_clr;
    assign integ_hold_o = r_integ_hold;
    assign lock_o       = r_lock;
    assign win_valid_o  = r_win_valid;
    assign win_mean_o   = r_win_mean;
endmodule

// File: tb/tb_cfo_loop_ctrl.sv
// Bench for cfo_loop_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_cfo_loop_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_i = 1'b0;
    logic        force_reacq_i = 1'b0;
    logic        err_valid_i = 1'b0;
    logic [23:0] phase_err_i = '0;
    logic [1:0]  gain_sel_o;
    logic        integ_clr_o;
    logic        integ_hold_o;
    logic        lock_o;
    logic [2:0]  state_o;
    logic        win_valid_o;
    logic [22:0] win_mean_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_wins   = 0;

    cfo_loop_ctrl dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .force_reacq_i(force_reacq_i),
        .err_valid_i(err_valid_i), .phase_err_i(phase_err_i), .gain_sel_o(gain_sel_o),
        .integ_clr_o(integ_clr_o), .integ_hold_o(integ_hold_o), .lock_o(lock_o),
        .state_o(state_o), .win_valid_o(win_valid_o), .win_mean_o(win_mean_o)
    );

    always #5 clk = ~clk;

    // Reference model: state as an int, window held as a running sum and sample count.
    int m_state = 0, m_sum = 0, m_n = 0, m_lock = 0, m_loss = 0, m_acq = 0, m_mean = 0;
    bit m_wv = 0;

    function automatic void model_step(input bit r, input bit en, input bit frc,
                                       input bit vld, input logic [23:0] err);
        int nxt, e, mag, mean;
        m_wv = 0;
        if (r) begin
            m_state = 0; m_sum = 0; m_n = 0; m_lock = 0; m_loss = 0; m_acq = 0; m_mean = 0;
            return;
        end
        nxt = m_state;
        if (!en) nxt = 0;
        else if (frc && m_state != 0) nxt = 1;
        else if (m_state == 0) nxt = 1;
        else if (m_state == 1) nxt = 2;
        else if (vld) begin
            e   = int'($signed(err));
            mag = (e >= 0) ? e : ((e == -8388608) ? 8388607 : -e);
            m_sum += mag;
            m_n   += 1;
            if (m_n == 16) begin
                mean   = m_sum / 16;
                m_mean = mean;
                m_wv   = 1;
                m_sum  = 0;
                m_n    = 0;
                if (m_state == 2) begin
                    m_lock = (mean < 524288) ? m_lock + 1 : 0;
                    m_acq  = m_acq + 1;
                    if (m_lock == 4) nxt = 3;
                    else if (m_acq == 64) nxt = 1;
                end else begin
                    m_loss = (mean > 2097152) ? m_loss + 1 : 0;
                    if (m_state == 3) m_lock = (mean < 131072) ? m_lock + 1 : 0;
                    if (m_loss == 2) nxt = 2;
                    else if (m_state == 3 && m_lock == 4) nxt = 4;
                    else if (m_state == 4 && mean >= 524288) nxt = 3;
                end
            end
        end
        if (nxt != m_state) begin
            m_sum = 0; m_n = 0; m_lock = 0; m_acq = 0;
            if (!((m_state == 3 && nxt == 4) || (m_state == 4 && nxt == 3))) m_loss = 0;
            m_state = nxt;
        end
    endfunction

    function automatic logic [31:0] model_outs();
        logic [2:0] st;
        logic [1:0] g;
        st = 3'(m_state);
        g  = (m_state == 3) ? 2'd1 : (m_state == 4) ? 2'd2 : 2'd0;
        return {st, g, (m_state == 1), (m_state == 0), (m_state == 3 || m_state == 4),
                m_wv, 23'(m_mean)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit en, input bit frc, input bit vld,
                       input logic [23:0] err);
        rst = r; enable_i = en; force_reacq_i = frc; err_valid_i = vld; phase_err_i = err;
        @(posedge clk);
        model_step(r, en, frc, vld, err);
        #1;
        check("outs", {32'd0, state_o, gain_sel_o, integ_clr_o, integ_hold_o, lock_o,
                       win_valid_o, win_mean_o}, {32'd0, model_outs()});
        if (win_valid_o) begin
            n_wins++;
            $display("window %0d: mean=%0d state=%0d lock=%0d", n_wins, win_mean_o, state_o, lock_o);
        end
    endtask

    task automatic run(input int n, input logic [23:0] err);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 1, err);
    endtask

    initial begin
        int wins0, amp, cls;
        logic [23:0] e;
        logic [23:0] alt;

        // 1: reset, acquisition, tracking, fine
        cyc(1, 0, 0, 0, '0);
        cyc(1, 1, 0, 1, 24'd100000);
        check("reset", {state_o, gain_sel_o, integ_clr_o, integ_hold_o, lock_o, win_valid_o, win_mean_o},
              {3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 23'd0});
        cyc(0, 1, 0, 1, 24'd100000);
        check("clear_state", state_o, 1);
        check("clear_pulse", integ_clr_o, 1);
        cyc(0, 1, 0, 1, 24'd100000);
        check("acq_state", state_o, 2);
        check("acq_clr_low", integ_clr_o, 0);
        run(63, 24'd100000);
        check("acq_before_lock", state_o, 2);
        run(1, 24'd100000);
        check("track_state", state_o, 3);
        check("track_lock", lock_o, 1);
        check("track_gain", gain_sel_o, 1);
        run(64, 24'd100000);
        check("fine_gain", gain_sel_o, 2);
        check("fine_mean", win_mean_o, 100000);

        // 2: loss of lock through TRACK back to ACQ
        run(16, -24'sd3000000);
        check("fine_to_track", state_o, 3);
        check("lock_kept", lock_o, 1);
        run(16, -24'sd3000000);
        check("loss_to_acq", state_o, 2);
        check("loss_unlock", lock_o, 0);
        check("loss_no_clr", integ_clr_o, 0);

        // 3: acquisition timeout
        run(1023, 24'd1000000);
        check("pre_timeout", state_o, 2);
        run(1, 24'd1000000);
        check("timeout_clear", state_o, 1);
        check("timeout_pulse", integ_clr_o, 1);
        run(1, 24'd1000000);
        check("timeout_reacq", state_o, 2);

        // 4: saturation and truncating mean
        run(16, 24'h800000);
        check("sat_mean", win_mean_o, 8388607);
        alt = 24'd100000;
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 1, (i % 2 == 0) ? alt : 24'd0);
        check("alt_mean", win_mean_o, 50000);

        // 5: forced reacquisition discards the partial window
        run(48, 24'd100000);
        check("relock", state_o, 3);
        run(8, 24'd100000);
        cyc(0, 1, 1, 1, 24'd100000);
        check("force_clear", state_o, 1);
        cyc(0, 1, 0, 1, 24'd100000);
        wins0 = n_wins;
        run(15, 24'd100000);
        check("no_early_win", n_wins - wins0, 0);
        run(1, 24'd100000);
        check("fresh_win", win_valid_o, 1);
        cyc(0, 0, 1, 1, 24'd100000);
        check("disable_idle", state_o, 0);
        check("idle_hold", integ_hold_o, 1);

        // 6: sparse valids and reset mid-window
        cyc(0, 1, 0, 0, '0);
        cyc(0, 1, 0, 0, '0);
        wins0 = n_wins;
        for (int i = 0; i < 48; i++) cyc(0, 1, 0, (i % 3 == 2), 24'd200000);
        check("sparse_wins", n_wins - wins0, 1);
        check("sparse_mean", win_mean_o, 200000);
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, (i % 3 == 2), 24'd200000);
        cyc(1, 1, 0, 1, 24'd200000);
        check("mid_reset", {state_o, gain_sel_o, integ_clr_o, integ_hold_o, lock_o, win_valid_o, win_mean_o},
              {3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 23'd0});

        // Randomized regimes, each held long enough to span several windows
        for (int b = 0; b < 40; b++) begin
            cls = int'($urandom_range(0, 4));
            amp = (cls == 0) ? 30000 : (cls == 1) ? 200000 : (cls == 2) ? 1000000 : 3000000;
            for (int i = 0; i < 80; i++) begin
                if (cls == 4) e = 24'($urandom);
                else begin
                    e = 24'(amp + int'($urandom_range(0, 32'(amp / 4))));
                    if ($urandom_range(0, 1) == 1) e = -e;
                end
                cyc(($urandom_range(0, 999) == 0), ($urandom_range(0, 399) != 0),
                    ($urandom_range(0, 255) == 0), ($urandom_range(0, 3) != 0), e);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
